// File: rtl/traffic_light_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor_if
//
// Bundle between the signal-head observation point (master side: the
// intersection controller tap plus supervisor clear) and the
// traffic_light_monitor (slave side).
//
// Signals
//   light        master -> slave  3-bit head drive (001 green, 010 yellow, 100 red)
//   clear        master -> slave  synchronous clear of fault / fault_count / cycle_count
//   phase        slave -> master  0 green, 1 yellow, 2 red, 3 unsynced (FSM state)
//   dwell        slave -> master  cycles spent in current phase, saturating
//   err_valid    slave -> master  one-cycle error pulse
//   err_code     slave -> master  1 invalid, 2 illegal transition, 3 short dwell, 4 timeout
//   fault        slave -> master  sticky error flag
//   fault_count  slave -> master  error events, saturating at 255
//   cycle_done   slave -> master  one-cycle pulse on legal red->green
//   cycle_count  slave -> master  completed cycles, wrapping
//
// Handshake: there is no valid/ready flow control. light and clear are
// sampled on every rising clock edge; err_valid and cycle_done are single
// cycle qualifiers for err_code and cycle_count respectively, and the
// receiver must be able to observe every cycle (no backpressure).
//
// Parameter DW must match the DW of the traffic_light_monitor instance.
// -----------------------------------------------------------------------------
interface traffic_light_monitor_if #(
  parameter int DW = 16
);
  logic [2:0]    light;
  logic          clear;
  logic [1:0]    phase;
  logic [DW-1:0] dwell;
  logic          err_valid;
  logic [2:0]    err_code;
  logic          fault;
  logic [7:0]    fault_count;
  logic          cycle_done;
  logic [15:0]   cycle_count;

  modport master (
    output light,
    output clear,
    input  phase,
    input  dwell,
    input  err_valid,
    input  err_code,
    input  fault,
    input  fault_count,
    input  cycle_done,
    input  cycle_count
  );

  modport slave (
    input  light,
    input  clear,
    output phase,
    output dwell,
    output err_valid,
    output err_code,
    output fault,
    output fault_count,
    output cycle_done,
    output cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Receive-side checker for the 3-bit signal-head drive. Samples light every
// clock, tracks the phase (GREEN -> YELLOW -> RED -> GREEN), and reports
// invalid codes, out-of-order transitions, short dwells and (optionally)
// dwell timeouts. Counts faults and completed signal cycles.
//
// Ports
//   clock   input   rising-edge clock
//   reset   input   asynchronous, active-high reset
//   bus     slave modport of traffic_light_monitor_if (light/clear in,
//           phase/dwell/err_*/fault*/cycle_* out); bus DW must equal DW here.
//
// Optional feature macro: TLM_TIMEOUT_EN
//   defined   -> error code 4 when dwell passes the phase's *_MAX value
//   undefined -> no timeout logic, *_MAX parameters only range-checked
//
// All outputs are registered and reflect the light value sampled at the
// same rising edge (phase is the FSM state itself).
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 100,
  parameter int YELLOW_MIN = 20,
  parameter int RED_MIN    = 100,
  parameter int GREEN_MAX  = 200,
  parameter int YELLOW_MAX = 40,
  parameter int RED_MAX    = 200,
  parameter int DW         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2,
    ST_UNSYNC = 2'd3
  } state_e;

  localparam logic [2:0] CODE_GREEN  = 3'b001;
  localparam logic [2:0] CODE_YELLOW = 3'b010;
  localparam logic [2:0] CODE_RED    = 3'b100;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_INVALID = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [DW-1:0] DWELL_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DWELL_SAT = {DW{1'b1}};

  // Limits must stay below the saturation value so a saturated counter can
  // never be mistaken for an in-range dwell.
  if (GREEN_MIN  >= (2**DW) - 1 || YELLOW_MIN >= (2**DW) - 1 ||
      RED_MIN    >= (2**DW) - 1 || GREEN_MAX  >= (2**DW) - 1 ||
      YELLOW_MAX >= (2**DW) - 1 || RED_MAX    >= (2**DW) - 1) begin : g_bad_limits
    $error("traffic_light_monitor: MIN/MAX limits must be below 2^DW-1");
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e        state_q,       state_d;
  logic [2:0]    last_light_q,  last_light_d;
  logic [DW-1:0] dwell_q,       dwell_d;
  logic          err_valid_q,   err_valid_d;
  logic [2:0]    err_code_q,    err_code_d;
  logic          fault_q,       fault_d;
  logic [7:0]    fault_count_q, fault_count_d;
  logic          cycle_done_q,  cycle_done_d;
  logic [15:0]   cycle_count_q, cycle_count_d;

  // ---------------------------------------------------------------------------
  // Decode of the sampled and previous code
  // ---------------------------------------------------------------------------
  state_e        light_state;
  logic          light_valid;
  logic          last_valid;
  state_e        succ_state;
  logic [DW-1:0] min_sel;
  logic          timeout_hit;

  always_comb begin
    light_state = ST_UNSYNC;
    case (bus.light)
      CODE_GREEN:  light_state = ST_GREEN;
      CODE_YELLOW: light_state = ST_YELLOW;
      CODE_RED:    light_state = ST_RED;
      default:     light_state = ST_UNSYNC;
    endcase
  end

  assign light_valid = (light_state != ST_UNSYNC);

  // last_light resets to 000, so an invalid code straight out of reset is
  // not treated as entry into an invalid run.
  assign last_valid = (last_light_q == CODE_GREEN)  ||
                      (last_light_q == CODE_YELLOW) ||
                      (last_light_q == CODE_RED);

  always_comb begin
    succ_state = ST_UNSYNC;
    min_sel    = '0;
    case (state_q)
      ST_GREEN: begin
        succ_state = ST_YELLOW;
        min_sel    = DW'(GREEN_MIN);
      end
      ST_YELLOW: begin
        succ_state = ST_RED;
        min_sel    = DW'(YELLOW_MIN);
      end
      ST_RED: begin
        succ_state = ST_GREEN;
        min_sel    = DW'(RED_MIN);
      end
      default: begin
        succ_state = ST_UNSYNC;
        min_sel    = '0;
      end
    endcase
  end

`ifdef TLM_TIMEOUT_EN
  logic [DW-1:0] max_sel;

  always_comb begin
    max_sel = DWELL_SAT;
    case (state_q)
      ST_GREEN:  max_sel = DW'(GREEN_MAX);
      ST_YELLOW: max_sel = DW'(YELLOW_MAX);
      ST_RED:    max_sel = DW'(RED_MAX);
      default:   max_sel = DWELL_SAT;
    endcase
  end

  // Only meaningful on a "same code" edge: dwell moves MAX -> MAX+1 exactly
  // once per phase occurrence because dwell only grows until the phase ends.
  assign timeout_hit = (dwell_q == max_sel);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       err_hit;
  logic [2:0] err_kind;

  always_comb begin
    state_d      = state_q;
    last_light_d = bus.light;
    dwell_d      = dwell_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    cycle_done_d = 1'b0;
    err_hit      = 1'b0;
    err_kind     = ERR_NONE;

    // Clear takes effect before any error or cycle completion on this edge.
    fault_d       = bus.clear ? 1'b0  : fault_q;
    fault_count_d = bus.clear ? 8'd0  : fault_count_q;
    cycle_count_d = bus.clear ? 16'd0 : cycle_count_q;

    if (!light_valid) begin
      state_d = ST_UNSYNC;
      dwell_d = '0;
      if (last_valid) begin
        err_hit  = 1'b1;
        err_kind = ERR_INVALID;
      end
    end else if (state_q == ST_UNSYNC) begin
      // Resynchronise on the first valid code without judging it.
      state_d = light_state;
      dwell_d = DWELL_ONE;
    end else if (bus.light == last_light_q) begin
      if (dwell_q != DWELL_SAT) begin
        dwell_d = dwell_q + DWELL_ONE;
      end
      if (timeout_hit) begin
        err_hit  = 1'b1;
        err_kind = ERR_TIMEOUT;
      end
    end else begin
      state_d = light_state;
      dwell_d = DWELL_ONE;
      if (light_state != succ_state) begin
        err_hit  = 1'b1;
        err_kind = ERR_ORDER;
      end else begin
        if (dwell_q < min_sel) begin
          err_hit  = 1'b1;
          err_kind = ERR_SHORT;
        end
        // A completed cycle counts even if red was short.
        if (state_q == ST_RED) begin
          cycle_done_d  = 1'b1;
          cycle_count_d = cycle_count_d + 16'd1;
        end
      end
    end

    if (err_hit) begin
      err_valid_d = 1'b1;
      err_code_d  = err_kind;
      fault_d     = 1'b1;
      if (fault_count_d != 8'hFF) begin
        fault_count_d = fault_count_d + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_UNSYNC;
      last_light_q  <= 3'b000;
      dwell_q       <= '0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      fault_q       <= 1'b0;
      fault_count_q <= 8'd0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      last_light_q  <= last_light_d;
      dwell_q       <= dwell_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      fault_q       <= fault_d;
      fault_count_q <= fault_count_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.phase       = state_q;
  assign bus.dwell       = dwell_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_code    = err_code_q;
  assign bus.fault       = fault_q;
  assign bus.fault_count = fault_count_q;
  assign bus.cycle_done  = cycle_done_q;
  assign bus.cycle_count = cycle_count_q;

endmodule
